// File: rtl/pipelined_word_demux.sv
// Pipelined 1:WORDS_OUT word distributor: a tree of registered fan-out layers routes each
// word, with its remaining select bits, toward one holding slot per destination.
module pipelined_word_demux #(
  parameter int unsigned DWIDTH        = 32,
  parameter int unsigned WORDS_OUT     = 16,
  parameter int unsigned SEL_PER_LAYER = 2,
  localparam int unsigned SEL_NUM      = $clog2(WORDS_OUT),
  localparam int unsigned LATENCY      = (SEL_NUM + SEL_PER_LAYER - 1) / SEL_PER_LAYER
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  input  logic                        din_valid,
  input  logic [SEL_NUM-1:0]          sel,
  input  logic [DWIDTH-1:0]           din,
  output logic [DWIDTH*WORDS_OUT-1:0] dout,
  output logic [WORDS_OUT-1:0]        dout_valid,
  output logic                        busy
);

  function automatic int unsigned layer_hi(int unsigned j);
    return ((j + 1) * SEL_PER_LAYER < SEL_NUM) ? (j + 1) * SEL_PER_LAYER : SEL_NUM;
  endfunction

  for (genvar j = 0; j < LATENCY; j++) begin : g_layer
    localparam int unsigned Lo      = j * SEL_PER_LAYER;
    localparam int unsigned Hi      = layer_hi(j);
    localparam int unsigned Bits    = Hi - Lo;
    localparam int unsigned InNodes = 1 << Lo;
    localparam int unsigned Nodes   = 1 << Hi;
    localparam int unsigned InSelW  = SEL_NUM - Lo;
    localparam int unsigned OutSelW = SEL_NUM - Hi;

    logic [DWIDTH-1:0]  in_data [InNodes];
    logic [InNodes-1:0] in_valid;
    logic [InSelW-1:0]  in_sel  [InNodes];
    logic [Hi-1:0]      dest    [InNodes];

    logic [DWIDTH-1:0]  data_q  [Nodes];
    logic [DWIDTH-1:0]  data_d  [Nodes];
    logic [Nodes-1:0]   valid_q;
    logic [Nodes-1:0]   valid_d;

    if (j == 0) begin : g_src
      assign in_data[0] = din;
      assign in_valid   = din_valid;
      assign in_sel[0]  = sel;
    end else begin : g_src
      assign in_data  = g_layer[j-1].data_q;
      assign in_valid = g_layer[j-1].valid_q;
      assign in_sel   = g_layer[j-1].g_sel.sel_q;
    end

    // Child index keeps the already-consumed low select bits and appends this layer's digit.
    for (genvar i = 0; i < InNodes; i++) begin : g_dest
      assign dest[i] = Hi'(i) | (Hi'(in_sel[i][Bits-1:0]) << Lo);
    end

    always_comb begin
      data_d  = data_q;
      valid_d = '0;
      for (int i = 0; i < InNodes; i++) begin
        if (in_valid[i]) begin
          valid_d[dest[i]] = 1'b1;
          data_d[dest[i]]  = in_data[i];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        data_q  <= '{default: '0};
        valid_q <= '0;
      end else if (ena) begin
        data_q  <= data_d;
        valid_q <= valid_d;
      end
    end

    if (OutSelW > 0) begin : g_sel
      logic [OutSelW-1:0] sel_q [Nodes];
      logic [OutSelW-1:0] sel_d [Nodes];

      always_comb begin
        sel_d = sel_q;
        for (int i = 0; i < InNodes; i++) begin
          if (in_valid[i]) begin
            sel_d[dest[i]] = in_sel[i][InSelW-1:Bits];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          sel_q <= '{default: '0};
        end else if (ena) begin
          sel_q <= sel_d;
        end
      end
    end
  end

  // The last layer's registers are the output slots and strobes themselves.
  for (genvar k = 0; k < WORDS_OUT; k++) begin : g_out
    assign dout[k*DWIDTH +: DWIDTH] = g_layer[LATENCY-1].data_q[k];
  end
  assign dout_valid = g_layer[LATENCY-1].valid_q;

  if (LATENCY > 1) begin : g_busy
    logic [LATENCY-2:0] layer_busy;
    for (genvar j = 0; j < LATENCY - 1; j++) begin : g_or
      assign layer_busy[j] = |g_layer[j].valid_q;
    end
    assign busy = |layer_busy;
  end else begin : g_no_busy
    assign busy = 1'b0;
  end

endmodule

// File: tb/tb_pipelined_word_demux.sv
// Scoreboard bench driving three demux configurations (32/16/2, 8/8/2, 8/4/3) with a
// shared stimulus stream; each word's expected arrival edge is derived from its latency.
module tb_pipelined_word_demux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ena, din_valid;
  logic [3:0]  sel_a;
  logic [31:0] din;

  logic [511:0] dout_a;
  logic [15:0]  dv_a;
  logic         busy_a;
  logic [63:0]  dout_b;
  logic [7:0]   dv_b;
  logic         busy_b;
  logic [31:0]  dout_c;
  logic [3:0]   dv_c;
  logic         busy_c;

  pipelined_word_demux #(.DWIDTH(32), .WORDS_OUT(16), .SEL_PER_LAYER(2)) u_dut_a (
    .clk(clk), .rst(rst), .ena(ena), .din_valid(din_valid), .sel(sel_a), .din(din),
    .dout(dout_a), .dout_valid(dv_a), .busy(busy_a)
  );

  pipelined_word_demux #(.DWIDTH(8), .WORDS_OUT(8), .SEL_PER_LAYER(2)) u_dut_b (
    .clk(clk), .rst(rst), .ena(ena), .din_valid(din_valid), .sel(sel_a[2:0]),
    .din(din[7:0]), .dout(dout_b), .dout_valid(dv_b), .busy(busy_b)
  );

  pipelined_word_demux #(.DWIDTH(8), .WORDS_OUT(4), .SEL_PER_LAYER(3)) u_dut_c (
    .clk(clk), .rst(rst), .ena(ena), .din_valid(din_valid), .sel(sel_a[1:0]),
    .din(din[7:0]), .dout(dout_c), .dout_valid(dv_c), .busy(busy_c)
  );

  typedef struct {
    int unsigned acc;   // enabled-edge number that samples the word
    logic [3:0]  s;
    logic [31:0] data;
  } item_t;

  item_t       sb[$];
  int unsigned rd[3];
  int unsigned en_cnt;
  logic [31:0] exp_slot[3][16];
  logic [15:0] exp_dv[3];
  int          checks = 0;
  int          errors = 0;

  function automatic int unsigned lat(int d);
    return (d == 2) ? 1 : 2;
  endfunction

  function automatic int unsigned nwords(int d);
    return (d == 0) ? 16 : (d == 1) ? 8 : 4;
  endfunction

  function automatic logic [31:0] dmask(int d);
    return (d == 0) ? 32'hffff_ffff : 32'h0000_00ff;
  endfunction

  task automatic chk(string name, int d, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d idx%0d t=%0t got %h want %h", name, d, k, $time, act, exp);
    end
  endtask

  // Monitor: after each edge, retire due words from the scoreboard and compare all outputs.
  initial begin
    bit          r, e;
    item_t       it;
    int unsigned k;
    logic [31:0] act;
    logic [15:0] dv;
    logic        b;
    en_cnt = 0;
    for (int d = 0; d < 3; d++) begin
      rd[d]     = 0;
      exp_dv[d] = '0;
      for (int s = 0; s < 16; s++) exp_slot[d][s] = '0;
    end
    forever begin
      @(posedge clk);
      r = rst;
      e = ena;
      #1;
      if (r) begin
        for (int d = 0; d < 3; d++) begin
          rd[d]     = sb.size();
          exp_dv[d] = '0;
          for (int s = 0; s < 16; s++) exp_slot[d][s] = '0;
        end
      end else if (e) begin
        en_cnt++;
        for (int d = 0; d < 3; d++) begin
          exp_dv[d] = '0;
          if (rd[d] < sb.size()) begin
            it = sb[rd[d]];
            if (it.acc + lat(d) - 1 == en_cnt) begin
              k                = int'(it.s) % nwords(d);
              exp_dv[d][k]     = 1'b1;
              exp_slot[d][k]   = it.data & dmask(d);
              rd[d]++;
            end
          end
        end
      end
      for (int d = 0; d < 3; d++) begin
        case (d)
          0:       begin dv = dv_a;           b = busy_a; end
          1:       begin dv = {8'h00, dv_b};  b = busy_b; end
          default: begin dv = {12'h000, dv_c}; b = busy_c; end
        endcase
        chk("dout_valid", d, 0, {16'h0000, dv}, {16'h0000, exp_dv[d]});
        chk("busy", d, 0, {31'b0, b}, {31'b0, rd[d] < sb.size()});
        for (int s = 0; s < nwords(d); s++) begin
          case (d)
            0:       act = dout_a[s*32 +: 32];
            1:       act = {24'h0, dout_b[s*8 +: 8]};
            default: act = {24'h0, dout_c[s*8 +: 8]};
          endcase
          chk("slot", d, s, act, exp_slot[d][s]);
        end
      end
    end
  end

  task automatic step(bit v, logic [3:0] s, logic [31:0] d, bit e, bit r);
    item_t it;
    din_valid = v;
    sel_a     = s;
    din       = d;
    ena       = e;
    rst       = r;
    if (v && e && !r) begin
      it.acc  = en_cnt + 1;
      it.s    = s;
      it.data = d;
      sb.push_back(it);
    end
    @(negedge clk);
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    ena       = 1'b0;
    din_valid = 1'b0;
    sel_a     = '0;
    din       = '0;
    @(negedge clk);
    step(1'b0, 4'h0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 4'h0, 32'h0, 1'b1, 1'b1);
    idle(2);

    step(1'b1, 4'd9, 32'hA5A5_0001, 1'b1, 1'b0);
    idle(4);

    for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 32'(i + 100), 1'b1, 1'b0);
    idle(4);

    // Stall before arrival, then stall again while the strobe is up.
    step(1'b1, 4'd3, 32'd7, 1'b1, 1'b0);
    repeat (3) step(1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
    repeat (2) step(1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    idle(2);

    for (int i = 0; i < 8; i++) step(i % 2 == 0, 4'd5, $urandom, 1'b1, 1'b0);
    idle(3);

    step(1'b1, 4'd2, 32'd11, 1'b1, 1'b0);
    step(1'b1, 4'd6, 32'd12, 1'b1, 1'b0);
    step(1'b0, 4'h0, 32'h0, 1'b1, 1'b1);
    idle(3);

    repeat (400) begin
      step($urandom_range(0, 3) != 0, 4'($urandom), $urandom, $urandom_range(0, 7) != 0,
           $urandom_range(0, 49) == 0);
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
